// File: rtl/p2s_tx_if.sv
// rtl/p2s_tx_if.sv - word handshake and serial output bundle for p2s_tx
interface p2s_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic             din_rdy;
    logic             data;
    logic             vld;
    logic             last;
    logic             par_flag;
    logic             busy;

    // Word producer / serial consumer side
    modport master (
        output din,
        output din_vld,
        input  din_rdy,
        input  data,
        input  vld,
        input  last,
        input  par_flag,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  din,
        input  din_vld,
        output din_rdy,
        output data,
        output vld,
        output last,
        output par_flag,
        output busy
    );
endinterface

// File: rtl/p2s_tx.sv
// rtl/p2s_tx.sv - parallel-to-serial transmitter, LSB first, optional even parity bit (P2S_PARITY_EN)
module p2s_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic       clk,
    input  logic       rst,
    p2s_tx_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The state names what is on the output pins this cycle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef P2S_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif
    localparam logic [1:0] ST_GAP   = 2'd3;

    // cnt_q is the index of the data bit currently driven
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifndef P2S_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
`endif
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             data_q, data_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
`ifdef P2S_PARITY_EN
    logic             par_flag_q, par_flag_d;
    logic             par_q, par_d;
`endif

    logic             xfer;
    logic             end_word;
    logic             want_next;
    logic             take_next;
    logic [WIDTH-1:0] next_word;

    // Ready depends only on the holding buffer so it never loops back through din_vld
    assign xfer = bus.din_vld && !buf_full_q;

    // Next-state, next-output and buffer bookkeeping
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        gap_cnt_d  = gap_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        data_d     = 1'b0;
        vld_d      = 1'b0;
        last_d     = 1'b0;
`ifdef P2S_PARITY_EN
        par_flag_d = 1'b0;
        par_d      = par_q;
`endif
        end_word   = 1'b0;
        want_next  = 1'b0;
        take_next  = 1'b0;
        next_word  = buf_full_q ? buf_q : bus.din;

        case (state_q)
            ST_IDLE: begin
                want_next = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    data_d = sr_q[0];
                    vld_d  = 1'b1;
                    sr_d   = sr_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifndef P2S_PARITY_EN
                    last_d = (cnt_q == CNT_PEN);
`endif
                end else begin
`ifdef P2S_PARITY_EN
                    state_d    = ST_PAR;
                    data_d     = par_q;
                    vld_d      = 1'b1;
                    last_d     = 1'b1;
                    par_flag_d = 1'b1;
`else
                    end_word   = 1'b1;
`endif
                end
            end
`ifdef P2S_PARITY_EN
            ST_PAR: begin
                end_word = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    want_next = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A finished word either opens the idle gap or chains straight into the next word
        if (end_word) begin
            if (GAP > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = 4'd0;
            end else begin
                want_next = 1'b1;
            end
        end

        if (want_next) begin
            if (buf_full_q || xfer) begin
                take_next = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Starting a word drives its bit 0 immediately so latency is one edge
        if (take_next) begin
            state_d = ST_SHIFT;
            data_d  = next_word[0];
            vld_d   = 1'b1;
            sr_d    = next_word >> 1;
            cnt_d   = '0;
`ifdef P2S_PARITY_EN
            par_d   = ^next_word;
`endif
        end

        // Buffer drains when its word is loaded; a transfer not consumed directly lands in it
        if (take_next && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        if (xfer && !(take_next && !buf_full_q)) begin
            buf_d      = bus.din;
            buf_full_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            gap_cnt_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            data_q     <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
`ifdef P2S_PARITY_EN
            par_flag_q <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
`ifdef P2S_PARITY_EN
            par_flag_q <= par_flag_d;
            par_q      <= par_d;
`endif
        end
    end

    assign bus.din_rdy  = !buf_full_q;
    assign bus.data     = data_q;
    assign bus.vld      = vld_q;
    assign bus.last     = last_q;
    assign bus.busy     = (state_q != ST_IDLE) || buf_full_q;
`ifdef P2S_PARITY_EN
    assign bus.par_flag = par_flag_q;
`else
    assign bus.par_flag = 1'b0;
`endif

endmodule

// File: tb/tb_p2s_tx.sv
// tb/tb_p2s_tx.sv - directed self-checking bench for p2s_tx (GAP=0 and GAP=2 instances)
module tb_p2s_tx;
    localparam int W = 4;

    localparam int S_DATA = 0;
    localparam int S_VLD  = 1;
    localparam int S_LAST = 2;
    localparam int S_PAR  = 3;
    localparam int S_RDY  = 4;
    localparam int S_BUSY = 5;

    // Expected 16-cycle traces, bit i = cycle i after the first acceptance edge
`ifdef P2S_PARITY_EN
    localparam logic [15:0] E1_DATA = 16'h001B, E1_VLD = 16'h001F, E1_LAST = 16'h0010, E1_BUSY = 16'h001F;
    localparam logic [15:0] E2_DATA = 16'h00AA, E2_VLD = 16'h03FF, E2_LAST = 16'h0210, E2_RDY  = 16'hFFE1;
    localparam logic [15:0] E3_DATA = 16'h24CC, E3_VLD = 16'h7FFF, E3_LAST = 16'h4210;
    localparam int          E3_ACC  = 6;
    localparam logic [15:0] E4_DATA = 16'h0F03, E4_VLD = 16'h0F9F, E4_LAST = 16'h0810, E4_BUSY = 16'h3FFF;
    localparam logic [15:0] E6_DATA = 16'h0017, E6_VLD = 16'h03FF, E6_LAST = 16'h0210, E6_PAR  = 16'h0210;
`else
    localparam logic [15:0] E1_DATA = 16'h000B, E1_VLD = 16'h000F, E1_LAST = 16'h0008, E1_BUSY = 16'h000F;
    localparam logic [15:0] E2_DATA = 16'h005A, E2_VLD = 16'h00FF, E2_LAST = 16'h0088, E2_RDY  = 16'hFFF1;
    localparam logic [15:0] E3_DATA = 16'h096C, E3_VLD = 16'h0FFF, E3_LAST = 16'h0888;
    localparam int          E3_ACC  = 5;
    localparam logic [15:0] E4_DATA = 16'h0383, E4_VLD = 16'h03CF, E4_LAST = 16'h0208, E4_BUSY = 16'h0FFF;
    localparam logic [15:0] E6_DATA = 16'h0007, E6_VLD = 16'h00FF, E6_LAST = 16'h0088, E6_PAR  = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p2s_tx_if #(.WIDTH(W)) bus0 ();
    p2s_tx_if #(.WIDTH(W)) bus2 ();

    p2s_tx #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    p2s_tx #(.WIDTH(W), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [5:0] h0 [1024];
    logic [5:0] h2 [1024];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        h0[cyc % 1024] = {bus0.busy, bus0.din_rdy, bus0.par_flag, bus0.last, bus0.vld, bus0.data};
        h2[cyc % 1024] = {bus2.busy, bus2.din_rdy, bus2.par_flag, bus2.last, bus2.vld, bus2.data};
    end

    function automatic logic [15:0] vec(input bit g2, input int sig, input int start);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i] = g2 ? h2[(start + i) % 1024][sig] : h0[(start + i) % 1024][sig];
        end
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus0.din = 4'hF; bus0.din_vld = 1'b1;
        bus2.din = 4'hF; bus2.din_vld = 1'b1;
        step(1);
        rst = 1'b0;
        bus0.din_vld = 1'b0;
        bus2.din_vld = 1'b0;
        n_checks++; if (bus0.data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %b want 0", bus0.data); end
        n_checks++; if (bus0.vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", bus0.vld); end
        n_checks++; if (bus0.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bus0.last); end
        n_checks++; if (bus0.par_flag !== 1'b0) begin n_fail++; $display("FAIL reset_par: got %b want 0", bus0.par_flag); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_checks++; if (bus0.din_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", bus0.din_rdy); end
        step(1);
        n_checks++; if (bus0.vld !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_xfer_ignored: vld=%b busy=%b want 0 0", bus0.vld, bus0.busy); end
    endtask

    task automatic test_single;
        int e;
        e = cyc;
        bus0.din = 4'b1011; bus0.din_vld = 1'b1;
        step(1);
        bus0.din_vld = 1'b0;
        step(20);
        n_checks++; if (vec(0, S_DATA, e + 1) !== E1_DATA) begin n_fail++; $display("FAIL single_data: got %h want %h", vec(0, S_DATA, e + 1), E1_DATA); end
        n_checks++; if (vec(0, S_VLD, e + 1) !== E1_VLD) begin n_fail++; $display("FAIL single_vld: got %h want %h", vec(0, S_VLD, e + 1), E1_VLD); end
        n_checks++; if (vec(0, S_LAST, e + 1) !== E1_LAST) begin n_fail++; $display("FAIL single_last: got %h want %h", vec(0, S_LAST, e + 1), E1_LAST); end
        n_checks++; if (vec(0, S_BUSY, e + 1) !== E1_BUSY) begin n_fail++; $display("FAIL single_busy: got %h want %h", vec(0, S_BUSY, e + 1), E1_BUSY); end
        n_checks++; if (vec(0, S_RDY, e + 1) !== 16'hFFFF) begin n_fail++; $display("FAIL single_rdy: got %h want ffff", vec(0, S_RDY, e + 1)); end
    endtask

    task automatic test_back_to_back;
        int e;
        e = cyc;
        bus0.din = 4'hA; bus0.din_vld = 1'b1;
        step(1);
        bus0.din = 4'h5;
        step(1);
        bus0.din_vld = 1'b0;
        step(20);
        n_checks++; if (vec(0, S_DATA, e + 1) !== E2_DATA) begin n_fail++; $display("FAIL b2b_data: got %h want %h", vec(0, S_DATA, e + 1), E2_DATA); end
        n_checks++; if (vec(0, S_VLD, e + 1) !== E2_VLD) begin n_fail++; $display("FAIL b2b_vld: got %h want %h", vec(0, S_VLD, e + 1), E2_VLD); end
        n_checks++; if (vec(0, S_LAST, e + 1) !== E2_LAST) begin n_fail++; $display("FAIL b2b_last: got %h want %h", vec(0, S_LAST, e + 1), E2_LAST); end
        n_checks++; if (vec(0, S_RDY, e + 1) !== E2_RDY) begin n_fail++; $display("FAIL b2b_rdy: got %h want %h", vec(0, S_RDY, e + 1), E2_RDY); end
    endtask

    task automatic test_backpressure;
        logic [3:0] words [3];
        int e, idx, guard, acc3;
        logic rdy;
        words[0] = 4'hC; words[1] = 4'h6; words[2] = 4'h9;
        e = cyc; idx = 0; guard = 0; acc3 = -1;
        while (idx < 3 && guard < 40) begin
            bus0.din = words[idx]; bus0.din_vld = 1'b1;
            rdy = bus0.din_rdy;
            if (rdy && idx == 2) acc3 = cyc - e;
            step(1);
            if (rdy) idx++;
            guard++;
        end
        bus0.din_vld = 1'b0;
        n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_timeout: accepted %0d words want 3", idx); end
        step(20);
        n_checks++; if (acc3 != E3_ACC) begin n_fail++; $display("FAIL bp_stall: word3 accepted at cycle %0d want %0d", acc3, E3_ACC); end
        n_checks++; if (vec(0, S_DATA, e + 1) !== E3_DATA) begin n_fail++; $display("FAIL bp_data: got %h want %h", vec(0, S_DATA, e + 1), E3_DATA); end
        n_checks++; if (vec(0, S_VLD, e + 1) !== E3_VLD) begin n_fail++; $display("FAIL bp_vld: got %h want %h", vec(0, S_VLD, e + 1), E3_VLD); end
        n_checks++; if (vec(0, S_LAST, e + 1) !== E3_LAST) begin n_fail++; $display("FAIL bp_last: got %h want %h", vec(0, S_LAST, e + 1), E3_LAST); end
    endtask

    task automatic test_gap;
        int e;
        e = cyc;
        bus2.din = 4'h3; bus2.din_vld = 1'b1;
        step(1);
        bus2.din = 4'hE;
        step(1);
        bus2.din_vld = 1'b0;
        step(20);
        n_checks++; if (vec(1, S_DATA, e + 1) !== E4_DATA) begin n_fail++; $display("FAIL gap_data: got %h want %h", vec(1, S_DATA, e + 1), E4_DATA); end
        n_checks++; if (vec(1, S_VLD, e + 1) !== E4_VLD) begin n_fail++; $display("FAIL gap_vld: got %h want %h", vec(1, S_VLD, e + 1), E4_VLD); end
        n_checks++; if (vec(1, S_LAST, e + 1) !== E4_LAST) begin n_fail++; $display("FAIL gap_last: got %h want %h", vec(1, S_LAST, e + 1), E4_LAST); end
        n_checks++; if (vec(1, S_BUSY, e + 1) !== E4_BUSY) begin n_fail++; $display("FAIL gap_busy: got %h want %h", vec(1, S_BUSY, e + 1), E4_BUSY); end
    endtask

    task automatic test_reset_mid_word;
        int e;
        e = cyc;
        bus0.din = 4'hF; bus0.din_vld = 1'b1;
        step(1);
        bus0.din = 4'h3;
        step(1);
        bus0.din_vld = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(20);
        n_checks++; if (vec(0, S_DATA, e + 1) !== 16'h0003) begin n_fail++; $display("FAIL rstmid_data: got %h want 0003", vec(0, S_DATA, e + 1)); end
        n_checks++; if (vec(0, S_VLD, e + 1) !== 16'h0003) begin n_fail++; $display("FAIL rstmid_vld: got %h want 0003", vec(0, S_VLD, e + 1)); end
        n_checks++; if (vec(0, S_LAST, e + 1) !== 16'h0000) begin n_fail++; $display("FAIL rstmid_last: got %h want 0000", vec(0, S_LAST, e + 1)); end
        n_checks++; if (vec(0, S_RDY, e + 1) !== 16'hFFFD) begin n_fail++; $display("FAIL rstmid_rdy: got %h want fffd", vec(0, S_RDY, e + 1)); end
        n_checks++; if (vec(0, S_BUSY, e + 1) !== 16'h0003) begin n_fail++; $display("FAIL rstmid_busy: got %h want 0003", vec(0, S_BUSY, e + 1)); end
    endtask

    task automatic test_parity;
        int e;
        e = cyc;
        bus0.din = 4'b0111; bus0.din_vld = 1'b1;
        step(1);
        bus0.din = 4'b0000;
        step(1);
        bus0.din_vld = 1'b0;
        step(20);
        n_checks++; if (vec(0, S_DATA, e + 1) !== E6_DATA) begin n_fail++; $display("FAIL par_data: got %h want %h", vec(0, S_DATA, e + 1), E6_DATA); end
        n_checks++; if (vec(0, S_VLD, e + 1) !== E6_VLD) begin n_fail++; $display("FAIL par_vld: got %h want %h", vec(0, S_VLD, e + 1), E6_VLD); end
        n_checks++; if (vec(0, S_LAST, e + 1) !== E6_LAST) begin n_fail++; $display("FAIL par_last: got %h want %h", vec(0, S_LAST, e + 1), E6_LAST); end
        n_checks++; if (vec(0, S_PAR, e + 1) !== E6_PAR) begin n_fail++; $display("FAIL par_flag: got %h want %h", vec(0, S_PAR, e + 1), E6_PAR); end
    endtask

    initial begin
        rst = 1'b1;
        bus0.din = '0; bus0.din_vld = 1'b0;
        bus2.din = '0; bus2.din_vld = 1'b0;
        step(2);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gap();
        test_reset_mid_word();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
